// File: rtl/cordic_vectoring_unit_if.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_unit_if
//   Request/response bundle for the vectoring-mode CORDIC unit.
//
//   start  : request, taken only while the unit is idle
//   Xi, Yi : signed Q3.29 input vector, captured on the accepting edge
//   busy   : computation in progress
//   done   : one-cycle pulse, mag/phase valid in that cycle
//   mag    : signed Q3.29 magnitude, held until the next done or reset
//   phase  : signed Q3.29 angle in radians, held like mag
//
//   master : the requester (drives start/Xi/Yi)
//   slave  : the CORDIC unit (drives busy/done/mag/phase)
// -----------------------------------------------------------------------------
interface cordic_vectoring_unit_if #(
  parameter int N = 32
) ();
  logic                start;
  logic signed [N-1:0] Xi;
  logic signed [N-1:0] Yi;
  logic                busy;
  logic                done;
  logic signed [N-1:0] mag;
  logic signed [N-1:0] phase;

  modport master (
    output start, Xi, Yi,
    input  busy, done, mag, phase
  );

  modport slave (
    input  start, Xi, Yi,
    output busy, done, mag, phase
  );
endinterface

// File: rtl/cordic_vectoring_unit.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_unit
//   Iterative vectoring-mode CORDIC: from a Q3.29 vector (Xi, Yi) it returns
//   the magnitude and atan2(Yi, Xi) in Q3.29, one micro-rotation per clock on
//   a single shared datapath.
//
//   Parameters
//     N : data width, Q3.29 format, only 32 is supported
//     I : number of micro-rotations, 1..28
//
//   Ports
//     clk : clock, all state changes on the rising edge
//     rst : synchronous active-high reset, overrides everything
//     bus : cordic_vectoring_unit_if.slave (start/Xi/Yi in, busy/done/mag/phase out)
//
//   Timing: start accepted at edge E -> ITER for I edges -> SCALE -> DONE,
//   so done is high in the cycle after edge E+I+1.
// -----------------------------------------------------------------------------
module cordic_vectoring_unit #(
  parameter int N = 32,
  parameter int I = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  cordic_vectoring_unit_if.slave  bus
);

  localparam int JW = 5;

  localparam logic signed [N-1:0] PI   = N'(32'h6487_ED51);
  localparam logic signed [N-1:0] KINV = N'(32'h136E_9DB5);
  localparam logic signed [N-1:0] ONE  = N'(32'h2000_0000);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  state_t              state;
  logic [JW-1:0]       j;
  logic signed [N-1:0] x;
  logic signed [N-1:0] y;
  logic signed [N-1:0] z;
  logic                zero_vec;

  logic signed [N-1:0]   x_sh;
  logic signed [N-1:0]   y_sh;
  logic signed [N-1:0]   atan_j;
  logic signed [2*N-1:0] prod;
  logic                  unused_prod_bits;

  // atan(2^-idx) in Q3.29. Beyond idx 9 the angle equals 2^-idx to within
  // half an LSB, so the tail is a plain shift of 1.0.
  function automatic logic signed [N-1:0] arctan_lookup(input logic [JW-1:0] idx);
    logic signed [N-1:0] val;
    case (idx)
      5'd0:    val = N'(32'h1921_FB54);
      5'd1:    val = N'(32'h0ED6_3383);
      5'd2:    val = N'(32'h07D6_DD7E);
      5'd3:    val = N'(32'h03FA_B753);
      5'd4:    val = N'(32'h01FF_55BB);
      5'd5:    val = N'(32'h00FF_EAAE);
      5'd6:    val = N'(32'h007F_FD55);
      5'd7:    val = N'(32'h003F_FFAB);
      5'd8:    val = N'(32'h001F_FFF5);
      5'd9:    val = N'(32'h000F_FFFF);
      default: val = ONE >>> idx;
    endcase
    return val;
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    x_sh   = x >>> j;
    y_sh   = y >>> j;
    atan_j = arctan_lookup(j);
    prod   = $signed({{N{x[N-1]}}, x}) * $signed({{N{KINV[N-1]}}, KINV});
  end

  // Only prod[N+28:29] forms the magnitude (>>> 29 then truncate to N bits).
  assign unused_prod_bits = ^{prod[2*N-1:N+29], prod[28:0]};

  // NOTE: all state, including the output registers, is written with
  // non-blocking assignments so every register samples pre-edge values;
  // this is what makes the X/Y/Z micro-rotation a simultaneous update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      j         <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      zero_vec  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.mag   <= '0;
      bus.phase <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Fold the left half-plane onto the right one so the iterations
            // only have to cover (-pi/2, pi/2]. Yi = 0 on the negative axis
            // takes +PI so the result lands on +pi, never -pi.
            if (bus.Xi[N-1]) begin
              x <= -bus.Xi;
              y <= -bus.Yi;
              z <= bus.Yi[N-1] ? -PI : PI;
            end else begin
              x <= bus.Xi;
              y <= bus.Yi;
              z <= '0;
            end
            zero_vec <= (bus.Xi == '0) && (bus.Yi == '0);
            j        <= '0;
            bus.busy <= 1'b1;
            state    <= ITER;
          end
        end

        ITER: begin
          // Rotate towards the x axis; Z accumulates the angle undone.
          if (y[N-1]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_j;
          end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_j;
          end
          j <= j + 1'b1;
          if (j == JW'(I - 1)) begin
            state <= SCALE;
          end
        end

        SCALE: begin
          // Remove the CORDIC gain; the zero vector has no defined angle and
          // is forced to an exact 0/0 result.
          bus.mag   <= zero_vec ? '0 : prod[N+28:29];
          bus.phase <= zero_vec ? '0 : z;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_unit.sv
// -----------------------------------------------------------------------------
// tb_cordic_vectoring_unit
//   Scoreboard bench for cordic_vectoring_unit. The driver pushes the
//   hand-computed expected result of each accepted start into a queue; an
//   independent monitor pops and compares whenever done is seen, and also
//   checks latency, the single-cycle done pulse and output hold.
// -----------------------------------------------------------------------------
module tb_cordic_vectoring_unit;

  localparam int N     = 32;
  localparam int ITERS = 10;

  // Q3.29 constants used by the directed vectors.
  localparam logic signed [N-1:0] P_ONE   = 32'sh2000_0000;   //  1.0
  localparam logic signed [N-1:0] M_ONE   = 32'shE000_0000;   // -1.0
  localparam logic signed [N-1:0] P_1P5   = 32'sh3000_0000;   //  1.5
  localparam logic signed [N-1:0] M_1P5   = 32'shD000_0000;   // -1.5
  localparam logic signed [N-1:0] P_HALF  = 32'sh1000_0000;   //  0.5
  localparam logic signed [N-1:0] SQRT3_2 = 32'sh1BB6_7AE9;   //  0.8660254
  localparam logic signed [N-1:0] M_LSB   = 32'shFFFF_FFFF;   // -2^-29

  localparam longint E_ONE    = 536870912;    // 1.0
  localparam longint E_SQRT2  = 759250125;    // sqrt(2)
  localparam longint E_1P5RT2 = 1138875188;   // 1.5*sqrt(2)
  localparam longint E_PI     = 1686629713;   // pi
  localparam longint E_PI_2   = 843314857;    // pi/2
  localparam longint E_PI_3   = 562209904;    // pi/3
  localparam longint E_PI_4   = 421657428;    // pi/4
  localparam longint E_3PI_4  = 1264972285;   // 3pi/4

  typedef struct {
    string       name;
    longint      mag;
    longint      phase;
    longint      mag_tol;
    longint      ph_tol;
    bit          need_pos;
    int unsigned done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          hold_en = 1'b0;

  cordic_vectoring_unit_if #(.N(N)) bus ();

  cordic_vectoring_unit #(.N(N), .I(ITERS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp,
                           input longint tol);
    longint diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Present one vector for a single accepting edge and queue its expectation.
  task automatic issue(input string name, input logic signed [N-1:0] xi,
                       input logic signed [N-1:0] yi, input longint emag,
                       input longint eph, input bit exact, input bit need_pos);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Xi     = xi;
    bus.Yi     = yi;
    e.name     = name;
    e.mag      = emag;
    e.phase    = eph;
    e.mag_tol  = exact ? 0 : (emag >>> (ITERS - 1)) + 8;
    e.ph_tol   = exact ? 0 : (64'sd1 <<< (29 - (ITERS - 1))) + 4;
    e.need_pos = need_pos;
    e.done_cyc = cyc + 1 + ITERS + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.Xi    = ~xi;       // later input changes must not matter
    bus.Yi    = ~yi;
    check({name, "_busy"}, bus.busy, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_size", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic run_vec(input string name, input logic signed [N-1:0] xi,
                         input logic signed [N-1:0] yi, input longint emag,
                         input longint eph, input bit exact, input bit need_pos);
    issue(name, xi, yi, emag, eph, exact, need_pos);
    drain();
  endtask

  // Monitor: scoreboard pop on done, plus pulse-width and hold checks.
  initial begin
    bit                  prev_done;
    exp_t                e;
    logic signed [N-1:0] last_mag;
    logic signed [N-1:0] last_phase;
    prev_done  = 1'b0;
    last_mag   = '0;
    last_phase = '0;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_one_cycle", bus.done, 0);
      if (bus.done) begin
        check("busy_low_at_done", bus.busy, 0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected no done", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_latency"}, cyc, e.done_cyc);
          check_tol({e.name, "_mag"}, bus.mag, e.mag, e.mag_tol);
          check_tol({e.name, "_phase"}, bus.phase, e.phase, e.ph_tol);
          if (e.need_pos) check({e.name, "_phase_positive"}, bus.phase > 0, 1);
        end
        last_mag   = bus.mag;
        last_phase = bus.phase;
        hold_en    = 1'b1;
      end else if (hold_en) begin
        check("mag_hold", bus.mag, last_mag);
        check("phase_hold", bus.phase, last_phase);
      end
      prev_done = bus.done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.Xi    = '0;
    bus.Yi    = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_mag", bus.mag, 0);
    check("reset_phase", bus.phase, 0);
    rst = 1'b0;

    run_vec("pos_x",      P_ONE,  '0,      E_ONE,    0,        1'b0, 1'b0);
    run_vec("pos_y",      '0,     P_ONE,   E_ONE,    E_PI_2,   1'b0, 1'b0);
    run_vec("q4_diag",    P_ONE,  M_ONE,   E_SQRT2,  -E_PI_4,  1'b0, 1'b0);
    run_vec("neg_x",      M_ONE,  '0,      E_ONE,    E_PI,     1'b0, 1'b1);
    run_vec("neg_x_lsb",  M_ONE,  M_LSB,   E_ONE,    -E_PI,    1'b0, 1'b0);
    run_vec("zero_vec",   '0,     '0,      0,        0,        1'b1, 1'b0);
    run_vec("neg_y",      '0,     M_ONE,   E_ONE,    -E_PI_2,  1'b0, 1'b0);
    run_vec("q2_diag",    M_ONE,  P_ONE,   E_SQRT2,  E_3PI_4,  1'b0, 1'b1);
    run_vec("max_q1",     P_1P5,  P_1P5,   E_1P5RT2, E_PI_4,   1'b0, 1'b0);
    run_vec("max_q3",     M_1P5,  M_1P5,   E_1P5RT2, -E_3PI_4, 1'b0, 1'b0);
    run_vec("sixty_deg",  P_HALF, SQRT3_2, E_ONE,    E_PI_3,   1'b0, 1'b0);

    // start held high with changing vectors through busy and DONE:
    // only the first vector may be accepted.
    begin
      exp_t e;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.Xi     = M_ONE;
      bus.Yi     = P_ONE;
      e.name     = "spam";
      e.mag      = E_SQRT2;
      e.phase    = E_3PI_4;
      e.mag_tol  = (E_SQRT2 >>> (ITERS - 1)) + 8;
      e.ph_tol   = (64'sd1 <<< (29 - (ITERS - 1))) + 4;
      e.need_pos = 1'b1;
      e.done_cyc = cyc + 1 + ITERS + 1;
      sb.push_back(e);
      for (int k = 0; k < ITERS + 2; k++) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.Xi    = $signed($urandom);
        bus.Yi    = $signed($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      repeat (ITERS + 4) @(negedge clk);
    end

    // Reset at iteration 4 discards the computation.
    begin
      exp_t e;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.Xi     = P_ONE;
      bus.Yi     = M_ONE;
      e.name     = "aborted";
      e.mag      = E_SQRT2;
      e.phase    = -E_PI_4;
      e.mag_tol  = 0;
      e.ph_tol   = 0;
      e.need_pos = 1'b0;
      e.done_cyc = cyc + 1 + ITERS + 1;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      hold_en = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_mag", bus.mag, 0);
      check("abort_phase", bus.phase, 0);
      void'(sb.pop_back());
      repeat (ITERS + 5) @(negedge clk);
    end

    run_vec("after_abort", '0, M_ONE, E_ONE, -E_PI_2, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring_unit.md
Name: cordic_vectoring_unit

Overview:
- Iterative CORDIC in vectoring mode; the inverse of the rotation-mode CORDIC unit.
- Takes a Q3.29 vector (Xi, Yi) and returns its magnitude and phase, i.e. atan2(Yi, Xi), in Q3.29.
- Runs one micro-rotation per clock through a single shared datapath, under a start/busy/done handshake.
- Reuses the existing arctan_lookup table module, indexed by the iteration counter.

Parameters:
- N, 32: data width. Fixed-point format is Q3.29; only N=32 is supported.
- I, 10: number of micro-rotations. Legal range 1..28.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- Xi  input  N  signed Q3.29 x component. Legal range |Xi| <= 1.5.
- Yi  input  N  signed Q3.29 y component. Legal range |Yi| <= 1.5.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse; mag and phase are valid in that cycle.
- mag  output  N  signed Q3.29 magnitude, >= 0. Held until the next done or reset.
- phase  output  N  signed Q3.29 angle in radians, range (-pi, +pi]. Held like mag.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, mag=0, phase=0; iteration counter and datapath registers cleared.
  - rst has priority over everything, including start and an in-flight computation. A computation interrupted by reset is discarded and no done is produced.
- States: IDLE, ITER, SCALE, DONE.
- IDLE:
  - If start=1, capture the inputs with quadrant pre-rotation, clear iteration counter j, and go to ITER with busy=1.
  - If Xi >= 0: X=Xi, Y=Yi, Z=0.
  - If Xi < 0: X=-Xi, Y=-Yi, Z=+PI when Yi >= 0, else Z=-PI. PI = 0x6487ED51.
  - Zero vector (Xi=0 and Yi=0): set a zero flag. The final outputs are then forced to mag=0, phase=0.
- ITER, once per cycle for j = 0..I-1:
  - If Y < 0: X <= X - (Y>>>j); Y <= Y + (X>>>j); Z <= Z - atan(2^-j).
  - Otherwise: X <= X + (Y>>>j); Y <= Y - (X>>>j); Z <= Z + atan(2^-j).
  - All updates use the old X/Y values (simultaneous update). Shifts are arithmetic.
  - Adds and subtracts wrap modulo 2^N. No overflow occurs within the legal input range, since the peak magnitude is 1.5*sqrt2*1.6468 < 3.5.
  - After the j=I-1 update, go to SCALE.
- SCALE:
  - mag <= (X * KINV) >>> 29, using a full 2N-bit signed product truncated toward -inf.
  - KINV = 0x136E9DB5 (0.6072529 in Q3.29).
  - phase <= Z.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle, busy=0.
  - Then return to IDLE. start is not accepted in DONE.
- Latency: start sampled at edge E gives done high in the cycle after edge E+I+1. The next start is accepted at edge E+I+3 at the earliest.
- busy is high from the cycle after edge E through the SCALE cycle inclusive.
- start while busy or in DONE: ignored. No queuing and no error flag.
- Inputs are captured only at the accepting edge. Changes to Xi/Yi during busy have no effect.
- Boundary values:
  - Xi<0, Yi=0 gives phase=+PI, never -PI.
  - Xi>0, Yi=0 gives phase within tolerance of 0.
- Accuracy:
  - |phase error| <= 2^-(I-1) rad + 4 LSB.
  - |mag error| <= 2^-(I-1)*mag + 8 LSB.
  - KINV is not corrected for finite I.

Test Plan:
- Reset, then (Xi,Yi) = (0x20000000, 0) with I=10: done pulses exactly 11 cycles after the start edge. mag within tol of 0x20000000; phase within 2^-9 rad of 0.
- (0, 0x20000000): phase ≈ 0x3243F6A9 (pi/2), mag ≈ 1.0. (0x20000000, 0xE0000000) (1,-1): mag ≈ 759250125 (sqrt2), phase ≈ -421657428 (-pi/4).
- (0xE0000000, 0) (-1,0): phase within tol of +0x6487ED51 and positive, mag ≈ 1.0. (-1, -2^-29): phase ≈ -pi.
- (0, 0): done after the normal latency with mag=0 and phase=0 exactly.
- Assert start every cycle while busy: exactly one done per accepted start; outputs correspond only to the first captured vector; mag/phase are held stable between done pulses.
- Assert rst=1 for one cycle at iteration 4: the next cycle shows busy=0, done=0, mag=0, phase=0. No done pulse follows, and a fresh start afterwards completes normally.
